fetch_unit: RTL and testbench

Instruction fetch stage placed directly upstream of the single-cycle datapath. It generates sequential fetch addresses, issues them to an instruction memory with variable latency (at most one request in flight), and buffers returned words with their PCs in a small prefetch FIFO. It delivers `{pc, inst}` pairs to the datapath through a valid/ready handshake. A redirect (taken branch or jump) flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory port, redirect input and datapath handshake.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO holding {pc, inst} pairs; flush wins over push and pop.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_data,
   output logic [AW:0]  count,
   output fetch_entry_t head
);

   localparam int CW = AW + 1;

   fetch_entry_t mem [DEPTH];
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '{pc: 32'h0, inst: INST_NOP};
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + CW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + CW'(1);
         end
      end
   end

   // The extra wrap bit lets full and empty be told apart by pointer difference.
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, prefetch FIFO, redirect flush.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_state_e state;
   fetch_state_e state_next;
   logic [31:0]  fetch_pc;
   logic [31:0]  issued_pc;
   logic [AW:0]  count;
   fetch_entry_t head;
   fetch_entry_t push_entry;
   logic         grant;
   logic         push;
   logic         pop;
   logic         head_present;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         FETCH_IDLE: if (grant) state_next = FETCH_WAIT;
         FETCH_WAIT: begin
            if (bus.imem_rvalid) begin
               state_next = FETCH_IDLE;
            end else if (bus.redirect) begin
               state_next = FETCH_DROP;
            end
         end
         FETCH_DROP: if (bus.imem_rvalid) state_next = FETCH_IDLE;
         default:    state_next = FETCH_IDLE;
      endcase
   end

   always_comb begin
      head_present   = (count != '0);
      bus.imem_req   = (state == FETCH_IDLE) && (count < CW'(DEPTH)) && !bus.redirect;
      grant          = bus.imem_req && bus.imem_gnt;
      push           = (state == FETCH_WAIT) && bus.imem_rvalid && !bus.redirect;
      bus.inst_valid = head_present && !bus.redirect;
      pop            = bus.inst_valid && bus.inst_ready;
   end

   // A redirect retargets fetch immediately, even while a dropped response is pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         issued_pc <= '0;
      end else begin
         if (bus.redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
         end else if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (grant) begin
            issued_pc <= fetch_pc;
         end
      end
   end

   assign push_entry = '{pc: issued_pc, inst: bus.imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (bus.redirect),
      .push_data (push_entry),
      .count     (count),
      .head      (head)
   );

   assign bus.imem_addr = fetch_pc;
   assign bus.inst_out  = head_present ? head.inst : 32'h0;
   assign bus.inst_pc   = head_present ? head.pc   : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against a transaction-level reference model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic clk;
   logic rst;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks    = 0;
   int failures  = 0;
   int delivered = 0;

   // Reference model: pending deliveries, the address stream and the single in-flight request.
   logic [63:0] expq [$];
   logic [31:0] model_pc;
   logic [31:0] model_issued;
   bit          outstanding;
   bit          keep;
   int          wait_cnt;
   bit          popped;
   bit          mon_en;

   int          gnt_pct;
   int          rdy_pct;
   int          redir_pct;
   int          stray_pct;
   int          lat_max;
   bit          force_redir;
   logic [31:0] force_pc;

   function automatic void checkOutput(input string name, input logic [31:0] actual,
                                       input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h time=%0t", name, actual, expected, $time);
      end
   endfunction

   function automatic void timeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=bound_expired expected=condition_reached time=%0t", name, $time);
   endfunction

   // Monitor: compares the FIFO head against the scoreboard and retires consumed entries.
   always @(negedge clk) begin
      bit exp_valid;
      #2;
      popped = 1'b0;
      if (mon_en) begin
         exp_valid = (expq.size() != 0) && !bus.redirect;
         checkOutput("inst_valid", 32'(bus.inst_valid), 32'(exp_valid));
         if (exp_valid) begin
            checkOutput("inst_pc", bus.inst_pc, expq[0][63:32]);
            checkOutput("inst_out", bus.inst_out, expq[0][31:0]);
            if (bus.inst_ready) begin
               void'(expq.pop_front());
               popped = 1'b1;
               delivered++;
            end
         end
      end
   end

   task automatic applyStimulus();
      bit exp_req;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      if (outstanding) begin
         if (wait_cnt > 0) wait_cnt--;
         if (wait_cnt == 0) bus.imem_rvalid = 1'b1;
      end else if ($urandom_range(0, 99) < stray_pct) begin
         bus.imem_rvalid = 1'b1;
      end
      bus.imem_rdata  = $urandom;
      bus.imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
      bus.inst_ready  = ($urandom_range(0, 99) < rdy_pct);
      bus.redirect    = force_redir || ($urandom_range(0, 99) < redir_pct);
      if (force_redir) begin
         bus.redirect_pc = force_pc;
      end else if ($urandom_range(0, 3) == 0) begin
         bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end else begin
         bus.redirect_pc = $urandom;
      end
      force_redir = 1'b0;
      #3;
      exp_req = !outstanding && ((expq.size() + int'(popped)) < DEPTH) && !bus.redirect;
      checkOutput("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) checkOutput("imem_addr", bus.imem_addr, model_pc);
      if (bus.redirect) begin
         expq.delete();
         model_pc = {bus.redirect_pc[31:2], 2'b00};
         if (outstanding && bus.imem_rvalid) outstanding = 1'b0;
         else if (outstanding) keep = 1'b0;
      end else begin
         if (outstanding && bus.imem_rvalid) begin
            if (keep) expq.push_back({model_issued, bus.imem_rdata});
            outstanding = 1'b0;
         end
         if (exp_req && bus.imem_gnt) begin
            outstanding  = 1'b1;
            keep         = 1'b1;
            model_issued = model_pc;
            model_pc     = model_pc + 32'd4;
            wait_cnt     = $urandom_range(1, lat_max);
         end
      end
   endtask

   task automatic setMode(input int g, input int r, input int d, input int s, input int l);
      gnt_pct   = g;
      rdy_pct   = r;
      redir_pct = d;
      stray_pct = s;
      lat_max   = l;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   initial begin
      int guard;
      rst             = 1'b1;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.inst_ready  = 1'b0;
      mon_en          = 1'b0;
      force_redir     = 1'b0;
      force_pc        = 32'h0;
      outstanding     = 1'b0;
      keep            = 1'b0;
      wait_cnt        = 0;
      model_pc        = RESET_PC;
      model_issued    = 32'h0;
      setMode(100, 100, 0, 0, 1);

      #3;
      checkOutput("reset_inst_valid", 32'(bus.inst_valid), 32'h0);
      checkOutput("reset_inst_out", bus.inst_out, 32'h0);
      checkOutput("reset_inst_pc", bus.inst_pc, 32'h0);
      #4;
      rst    = 1'b0;
      mon_en = 1'b1;

      $display("[TB] streaming with 1-cycle memory");
      runCycles(12);

      $display("[TB] backpressure fills the prefetch FIFO");
      setMode(100, 0, 0, 0, 1);
      runCycles(10);
      setMode(100, 100, 0, 0, 1);
      runCycles(10);

      $display("[TB] redirect while a request is in flight");
      setMode(100, 100, 0, 0, 3);
      guard = 0;
      while (!(outstanding && wait_cnt >= 2) && guard < 200) begin
         applyStimulus();
         guard++;
      end
      if (guard >= 200) timeout("redirect_wait_setup");
      force_redir = 1'b1;
      force_pc    = 32'h0000_0100;
      runCycles(15);

      $display("[TB] redirect coinciding with a response");
      setMode(100, 0, 0, 0, 3);
      guard = 0;
      while (!(outstanding && wait_cnt == 1 && expq.size() == DEPTH - 1) && guard < 200) begin
         applyStimulus();
         guard++;
      end
      if (guard >= 200) timeout("redirect_rvalid_setup");
      force_redir = 1'b1;
      force_pc    = 32'h0000_0203;
      runCycles(3);
      setMode(100, 100, 0, 0, 1);
      runCycles(8);

      $display("[TB] address wrap at the top of memory");
      guard = 0;
      while (outstanding && guard < 20) begin
         applyStimulus();
         guard++;
      end
      force_redir = 1'b1;
      force_pc    = 32'hFFFF_FFF8;
      runCycles(12);

      $display("[TB] randomized traffic");
      setMode(70, 60, 5, 3, 3);
      runCycles(1500);

      $display("[TB] reset while a request is in flight");
      setMode(100, 0, 0, 0, 3);
      guard = 0;
      while (!(outstanding && expq.size() == 1) && guard < 200) begin
         applyStimulus();
         guard++;
      end
      if (guard >= 200) timeout("reset_setup");
      mon_en = 1'b0;
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.redirect    = 1'b0;
      bus.inst_ready  = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("midreset_inst_valid", 32'(bus.inst_valid), 32'h0);
      checkOutput("midreset_inst_out", bus.inst_out, 32'h0);
      checkOutput("midreset_inst_pc", bus.inst_pc, 32'h0);
      @(negedge clk);
      rst         = 1'b0;
      expq.delete();
      outstanding = 1'b0;
      keep        = 1'b0;
      model_pc    = RESET_PC;
      mon_en      = 1'b1;
      #3;
      checkOutput("post_reset_imem_req", 32'(bus.imem_req), 32'h1);
      checkOutput("post_reset_imem_addr", bus.imem_addr, RESET_PC);
      setMode(0, 100, 0, 100, 1);
      runCycles(3);
      setMode(100, 100, 0, 0, 2);
      runCycles(10);

      $display("[TB] randomized traffic after reset");
      setMode(80, 70, 4, 2, 3);
      runCycles(400);

      if (delivered < 100) timeout("delivered_volume");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
